io_periph_responder: RTL and testbench

- Peripheral-side responder for the CPU's memory-mapped IO chip-select interface; sits between the CPU IO decode logic and the board pins.
- Reads: debounces the 16 switches and returns one byte on io_rdata when switch_cs is high.
- Writes: latches LED data on led_cs and a 32-bit display value on seg_cs.
- Display: drives an 8-digit multiplexed hex seven-segment display with a scan FSM.

---
 rtl/io_pkg.sv | 23 ++
 rtl/seg_hex_decode.sv | 35 +++
 rtl/io_periph_responder.sv | 117 +++++++++++
 tb/tb_io_periph_responder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared constants and types for the IO peripheral responder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package io_pkg;

  // LED write sub-address encodings (addr_lo)
  localparam logic [1:0] LED_LO = 2'b00;  // led[7:0]  <= wdata[7:0]
  localparam logic [1:0] LED_HI = 2'b01;  // led[15:8] <= wdata[7:0]
  localparam logic [1:0] LED_HW = 2'b10;  // led       <= wdata[15:0]

  // Active-low cathode and anode patterns
  localparam logic [7:0] SEG_OFF  = 8'hFF;
  localparam logic [7:0] SEG_ZERO = 8'hC0;
  localparam logic [7:0] AN_OFF   = 8'hFF;

  localparam int NDIG = 8;

  // Scan FSM state: the digit currently lit
  typedef enum logic [2:0] {
    DIG0, DIG1, DIG2, DIG3, DIG4, DIG5, DIG6, DIG7
  } digit_t;

endpackage

// File: rtl/seg_hex_decode.sv
// Hex nibble to active-low seven-segment cathode pattern, decimal point off.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
// Ports: nibble (4-bit value), cat (bit7 = dp, bits[6:0] = g..a, active-low).
module seg_hex_decode
  import io_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] cat
);

  always_comb begin
    cat = SEG_OFF;
    case (nibble)
      4'h0: cat = SEG_ZERO;
      4'h1: cat = 8'hF9;
      4'h2: cat = 8'hA4;
      4'h3: cat = 8'hB0;
      4'h4: cat = 8'h99;
      4'h5: cat = 8'h92;
      4'h6: cat = 8'h82;
      4'h7: cat = 8'hF8;
      4'h8: cat = 8'h80;
      4'h9: cat = 8'h90;
      4'hA: cat = 8'h88;
      4'hB: cat = 8'h83;
      4'hC: cat = 8'hC6;
      4'hD: cat = 8'hA1;
      4'hE: cat = 8'h86;
      4'hF: cat = 8'h8E;
      default: cat = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/io_periph_responder.sv
// Memory-mapped IO responder: debounced switch reads, LED/display writes, 8-digit hex scan.
// Latency: reads combinational (0 cycles); writes take effect on the select edge; switch change reaches the read path after 3+DEB_CYCLES edges.
// Backpressure: none; every select is accepted in the cycle it is asserted.
// Ports: clk, rst_n (async active-low); switch_cs/led_cs/seg_cs, addr_lo, wdata from the CPU decode;
//        io_rdata back to the CPU; sw_in raw pins; led_out, seg_an, seg_cat to the board.
// Optional: define IO_SEG_LZ_BLANK_EN to blank digits above the most significant nonzero nibble.
module io_periph_responder
  import io_pkg::*;
#(
  parameter logic [19:0] DEB_CYCLES = 20'd1000000,
  parameter logic [16:0] SCAN_DIV   = 17'd100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        switch_cs,
  input  logic        led_cs,
  input  logic        seg_cs,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [7:0]  io_rdata,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_cat
);

  logic [15:0] sync1, sync2, cand, stable;
  logic [19:0] deb_cnt;
  logic [15:0] led;
  logic [31:0] seg_val;
  logic [16:0] psc;
  digit_t      idx;

  // Switch path: two-flop synchronizer, then a candidate must hold for
  // DEB_CYCLES consecutive cycles before being promoted to stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      cand    <= '0;
      stable  <= '0;
      deb_cnt <= '0;
    end else begin
      sync1 <= sw_in;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand    <= sync2;
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_CYCLES - 20'd1) begin
        stable <= cand;  // counter parks here until the next change
      end else begin
        deb_cnt <= deb_cnt + 20'd1;
      end
    end
  end

  // Zero-latency read so a single-cycle CPU sees the byte in the same cycle
  assign io_rdata = !switch_cs ? 8'h00 : (addr_lo[0] ? stable[15:8] : stable[7:0]);

  // CPU writes; LED and display selects are handled independently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led     <= '0;
      seg_val <= '0;
    end else begin
      if (led_cs) begin
        case (addr_lo)
          LED_LO:  led[7:0]  <= wdata[7:0];
          LED_HI:  led[15:8] <= wdata[7:0];
          LED_HW:  led       <= wdata[15:0];
          default: led       <= led;
        endcase
      end
      if (seg_cs)
        seg_val <= wdata;
    end
  end

  assign led_out = led;

  // Scan FSM: one digit per SCAN_DIV cycles, writes do not disturb timing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc <= '0;
      idx <= DIG0;
    end else if (psc == SCAN_DIV - 17'd1) begin
      psc <= '0;
      idx <= digit_t'(3'(idx + 3'd1));
    end else begin
      psc <= psc + 17'd1;
    end
  end

  logic [7:0] an_lit;
  assign an_lit = ~(8'b1 << idx);

  seg_hex_decode u_dec (
    .nibble (seg_val[{idx, 2'b00} +: 4]),
    .cat    (seg_cat)
  );

`ifdef IO_SEG_LZ_BLANK_EN
  // Most significant nonzero nibble; 0 when the whole value is zero so
  // digit 0 always shows.
  logic [2:0] msd;
  always_comb begin
    msd = 3'd0;
    for (int i = 0; i < NDIG; i++)
      if (seg_val[4*i +: 4] != 4'h0)
        msd = 3'(i);
  end
  assign seg_an = (3'(idx) > msd) ? AN_OFF : an_lit;
`else
  assign seg_an = an_lit;
`endif

endmodule

// File: tb/tb_io_periph_responder.sv
// Directed self-checking bench for io_periph_responder (DEB_CYCLES=4, SCAN_DIV=3).
// Latency: n/a.
// Backpressure: n/a.
module tb_io_periph_responder;

  logic        clk;
  logic        rst_n;
  logic        switch_cs, led_cs, seg_cs;
  logic [1:0]  addr_lo;
  logic [31:0] wdata;
  logic [7:0]  io_rdata;
  logic [15:0] sw_in;
  logic [15:0] led_out;
  logic [7:0]  seg_an;
  logic [7:0]  seg_cat;

  int passes = 0;
  int total  = 0;

  logic [7:0] an_tab [8];

  io_periph_responder #(
    .DEB_CYCLES (20'd4),
    .SCAN_DIV   (17'd3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .switch_cs (switch_cs),
    .led_cs    (led_cs),
    .seg_cs    (seg_cs),
    .addr_lo   (addr_lo),
    .wdata     (wdata),
    .io_rdata  (io_rdata),
    .sw_in     (sw_in),
    .led_out   (led_out),
    .seg_an    (seg_an),
    .seg_cat   (seg_cat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] an_exp(input int d);
`ifdef IO_SEG_LZ_BLANK_EN
    // Display value F1 has its top nonzero nibble at digit 1
    if (d > 1) return 8'hFF;
`endif
    return an_tab[d];
  endfunction

  initial begin
    bit found;
    an_tab[0] = 8'hFE; an_tab[1] = 8'hFD; an_tab[2] = 8'hFB; an_tab[3] = 8'hF7;
    an_tab[4] = 8'hEF; an_tab[5] = 8'hDF; an_tab[6] = 8'hBF; an_tab[7] = 8'h7F;

    rst_n = 1'b0; switch_cs = 1'b1; led_cs = 1'b0; seg_cs = 1'b0;
    addr_lo = 2'b00; wdata = '0; sw_in = '0;
    #2;
    chk("rst_led", led_out, 16'h0000);
    chk("rst_rdata", io_rdata, 8'h00);
    chk("rst_an", seg_an, 8'hFE);
    chk("rst_cat", seg_cat, 8'hC0);

    // Debounce: change applied right after edge 0, accepted at edge 7
    @(posedge clk); #1;
    rst_n = 1'b1;
    sw_in = 16'hA55A;
    tick(6);
    chk("deb_edge6", io_rdata, 8'h00);
    tick(1);
    chk("deb_edge7_lo", io_rdata, 8'h5A);
    addr_lo = 2'b01; #1;
    chk("deb_hi", io_rdata, 8'hA5);
    switch_cs = 1'b0; #1;
    chk("rd_nocs", io_rdata, 8'h00);
    switch_cs = 1'b1; addr_lo = 2'b00;

    // Return to zero, then a 3-cycle glitch must never be accepted
    sw_in = 16'h0000;
    tick(10);
    chk("deb_zero", io_rdata, 8'h00);
    sw_in = 16'h0001;
    tick(3);
    sw_in = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("glitch", io_rdata, 8'h00);
    end

    // LED writes (switch_cs held high alongside is harmless)
    led_cs = 1'b1; addr_lo = 2'b00; wdata = 32'h12345678;
    tick(1);
    chk("led_lo", led_out, 16'h0078);
    addr_lo = 2'b01; wdata = 32'h000000AB;
    tick(1);
    chk("led_hi", led_out, 16'hAB78);
    addr_lo = 2'b10; wdata = 32'h0000CAFE;
    tick(1);
    chk("led_hw", led_out, 16'hCAFE);
    addr_lo = 2'b11; wdata = 32'hFFFFFFFF;
    tick(1);
    chk("led_ign", led_out, 16'hCAFE);
    led_cs = 1'b0; addr_lo = 2'b10; wdata = 32'h00001111;
    tick(1);
    chk("led_nocs", led_out, 16'hCAFE);
    chk("rd_during_wr", io_rdata, 8'h00);

    // Simultaneous LED and display write, both take effect
    led_cs = 1'b1; seg_cs = 1'b1; addr_lo = 2'b10; wdata = 32'h000000F1;
    tick(1);
    led_cs = 1'b0; seg_cs = 1'b0; wdata = '0; addr_lo = 2'b00;
    chk("led_both", led_out, 16'h00F1);

    // Align to the first cycle of a digit 0 slot
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (seg_an != 8'hFE) found = 1'b1;
      else tick(1);
    end
    chk("find_leave0", {31'd0, found}, 32'd1);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick(1);
      if (seg_an == 8'hFE) found = 1'b1;
    end
    chk("find_enter0", {31'd0, found}, 32'd1);

    chk("scan_an0", seg_an, 8'hFE);
    chk("scan_cat0", seg_cat, 8'hF9);
    tick(1);
    chk("scan_an0_mid", seg_an, 8'hFE);
    tick(1);
    chk("scan_an0_end", seg_an, 8'hFE);
    tick(1);
    chk("scan_an1", seg_an, an_exp(1));
    chk("scan_cat1", seg_cat, 8'h8E);
    for (int d = 2; d < 8; d++) begin
      tick(3);
      chk("scan_an", seg_an, an_exp(d));
      chk("scan_cat", seg_cat, 8'hC0);
    end
    tick(3);
    chk("scan_wrap_an", seg_an, 8'hFE);
    chk("scan_wrap_cat", seg_cat, 8'hF9);

    // Advance to digit 5 with a debounced switch value present, then reset
    sw_in = 16'hA55A; addr_lo = 2'b01;
    tick(15);
    chk("pre_rst_an5", seg_an, an_exp(5));
    chk("pre_rst_rd", io_rdata, 8'hA5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_an", seg_an, 8'hFE);
    chk("mid_rst_cat", seg_cat, 8'hC0);
    chk("mid_rst_led", led_out, 16'h0000);
    chk("mid_rst_rd", io_rdata, 8'h00);

    // Release: digit 0 slot lasts a full SCAN_DIV after release
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rel_an_c0", seg_an, 8'hFE);
    tick(1);
    chk("rel_an_c1", seg_an, 8'hFE);
    tick(1);
    chk("rel_an_c2", seg_an, 8'hFE);
    tick(1);
    chk("rel_an_d1", seg_an, an_tab[1]);
    chk("rel_led", led_out, 16'h0000);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
